// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
// Holds the opcode constants, the state encoding, the ALU, ALUSrcB, PCSrc and
// fault-code encodings, and the packed bundle of control outputs that the
// output decoder hands to the top level.
package mips_ctrl_pkg;

  // Instruction[31:26] values that the control unit recognises.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // State encoding. Codes 12-14 are unused; the FSM treats them as illegal.
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_HALT    = 4'd15
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  // Every datapath control line driven from the current state.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       fault;
  } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Combinational control-output decoder for the multicycle MIPS controller.
// Ports:
//   state_i     - current FSM state
//   mem_ready_i - memory handshake; qualifies IRWrite/PCWrite in FETCH and
//                 instr_done in MEMWR
//   rst_n_i     - active-low reset; while low every output is 0
//   ctrl_o      - all datapath control lines plus instr_done and fault
// Any line not set for a state stays 0, so the HALT state drives no strobes.
module mc_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  input  logic   rst_n_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    if (rst_n_i) begin
      case (state_i)
        S_FETCH: begin
          ctrl_o.mem_read  = 1'b1;
          ctrl_o.alu_src_b = SRCB_FOUR;
          // IR and PC load only on the cycle the fetch actually completes.
          ctrl_o.ir_write  = mem_ready_i;
          ctrl_o.pc_write  = mem_ready_i;
        end
        S_DECODE: ctrl_o.alu_src_b = SRCB_IMM_SH2;
        S_MEMADR: begin
          ctrl_o.alu_src_a = 1'b1;
          ctrl_o.alu_src_b = SRCB_IMM;
        end
        S_MEMRD: begin
          ctrl_o.mem_read = 1'b1;
          ctrl_o.i_or_d   = 1'b1;
        end
        S_MEMWB: begin
          ctrl_o.mem_to_reg = 1'b1;
          ctrl_o.reg_write  = 1'b1;
          ctrl_o.instr_done = 1'b1;
        end
        S_MEMWR: begin
          ctrl_o.mem_write  = 1'b1;
          ctrl_o.i_or_d     = 1'b1;
          ctrl_o.instr_done = mem_ready_i;
        end
        S_EXECUTE: begin
          ctrl_o.alu_src_a = 1'b1;
          ctrl_o.alu_op    = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          ctrl_o.reg_dst    = 1'b1;
          ctrl_o.reg_write  = 1'b1;
          ctrl_o.instr_done = 1'b1;
        end
        S_ADDIEX: begin
          ctrl_o.alu_src_a = 1'b1;
          ctrl_o.alu_src_b = SRCB_IMM;
        end
        S_ADDIWB: begin
          ctrl_o.reg_write  = 1'b1;
          ctrl_o.instr_done = 1'b1;
        end
        S_BRANCH: begin
          ctrl_o.alu_src_a     = 1'b1;
          ctrl_o.alu_op        = ALUOP_SUB;
          ctrl_o.pc_write_cond = 1'b1;
          ctrl_o.pc_src        = PCSRC_ALUOUT;
          ctrl_o.instr_done    = 1'b1;
        end
        S_JUMP: begin
          ctrl_o.pc_write   = 1'b1;
          ctrl_o.pc_src     = PCSRC_JUMP;
          ctrl_o.instr_done = 1'b1;
        end
        S_HALT:  ctrl_o.fault = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath.
// Sequences fetch, decode, execute, memory and writeback for R-format, lw,
// sw, addi, beq and j. Illegal opcodes and memory timeouts park the FSM in a
// sticky HALT state that only reset leaves.
// Ports:
//   clk, rst_n        - rising-edge clock, synchronous active-low reset
//   opcode            - IR[31:26], consulted only in DECODE
//   mem_ready         - memory completes the current access this cycle
//   PCWrite..ALUOp    - datapath control lines
//   instr_done        - one-cycle pulse in the last cycle of an instruction
//   fault, fault_code - HALT indication and its cause
//   state             - current state encoding for debug
// Memory handshake: in FETCH, MEMRD and MEMWR the access is held (strobes
// stay asserted) until a cycle with mem_ready=1; that cycle completes the
// access and the FSM advances on the following edge. Every mem_ready=0 cycle
// in those states counts toward the watchdog, and the count clears whenever
// the state changes.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       instr_done,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [3:0] state
);

  localparam int WCW = ($clog2(MAX_WAIT + 1) < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

  state_e           state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [1:0]       fault_code_q, fault_code_d;
  // lw/sw choice captured in DECODE so MEMADR never looks at opcode again.
  logic             is_store_q, is_store_d;
  logic             in_mem_state;
  ctrl_t            ctrl;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    fault_code_d = fault_code_q;
    is_store_d   = is_store_q;
    in_mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                   (state_q == S_MEMWR);

    case (state_q)
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        is_store_d = (opcode == OP_SW);
        case (opcode)
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d      = S_HALT;
            fault_code_d = FAULT_ILLEGAL;
          end
        endcase
      end
      S_MEMADR:  state_d = is_store_q ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_HALT:    ;
      default: begin
        state_d      = S_HALT;
        fault_code_d = FAULT_ILLEGAL;
      end
    endcase

    // Watchdog: the counter saturates at WAIT_LIMIT because reaching it with
    // another stalled cycle forces HALT instead of incrementing.
    if (in_mem_state && !mem_ready) begin
      if (wait_cnt_q == WAIT_LIMIT) begin
        state_d      = S_HALT;
        fault_code_d = FAULT_TIMEOUT;
      end else begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end

    if (state_d != state_q) wait_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      wait_cnt_q   <= '0;
      fault_code_q <= FAULT_NONE;
      is_store_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      fault_code_q <= fault_code_d;
      is_store_q   <= is_store_d;
    end
  end

  mc_output_decode u_output_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .rst_n_i     (rst_n),
    .ctrl_o      (ctrl)
  );

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign PCSrc       = ctrl.pc_src;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign RegDst      = ctrl.reg_dst;
  assign MemToReg    = ctrl.mem_to_reg;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign instr_done  = ctrl.instr_done;
  assign fault       = ctrl.fault;
  assign fault_code  = rst_n ? fault_code_q : FAULT_NONE;
  assign state       = rst_n ? state_q : 4'd0;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control (MAX_WAIT = 15).
module tb_multicycle_control;

  localparam logic [5:0] T_RTYPE = 6'b000000;
  localparam logic [5:0] T_LW    = 6'b100011;
  localparam logic [5:0] T_SW    = 6'b101011;
  localparam logic [5:0] T_ADDI  = 6'b001000;
  localparam logic [5:0] T_BEQ   = 6'b000100;
  localparam logic [5:0] T_J     = 6'b000010;
  localparam int         N_RAND  = 40;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mem_ready = 1'b0;
  logic [5:0] opcode = '0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       RegDst, MemToReg, RegWrite, ALUSrcA, instr_done, fault;
  logic [1:0] PCSrc, ALUSrcB, ALUOp, fault_code;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_control #(.MAX_WAIT(15)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSrc(PCSrc), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .instr_done(instr_done), .fault(fault), .fault_code(fault_code),
    .state(state)
  );

  // Observed output bundle: state, fault_code, fault, instr_done, ALUOp,
  // ALUSrcB, ALUSrcA, RegWrite, MemToReg, RegDst, IRWrite, MemWrite,
  // MemRead, IorD, PCSrc, PCWriteCond, PCWrite.
  typedef struct packed {
    logic [3:0] st;
    logic [1:0] fcode;
    logic       flt;
    logic       done;
    logic [1:0] aluop;
    logic [1:0] srcb;
    logic       srca;
    logic       regwrite;
    logic       memtoreg;
    logic       regdst;
    logic       irwrite;
    logic       memwrite;
    logic       memread;
    logic       iord;
    logic [1:0] pcsrc;
    logic       pcwcond;
    logic       pcwrite;
  } obs_t;

  // One cycle of stimulus plus the state the DUT must be in during it.
  typedef struct packed {
    logic       mr;
    logic [5:0] op;
    logic [3:0] st;
  } cyc_t;

  typedef struct {
    logic       mr;
    logic [5:0] op;
    logic [3:0] st;
    logic       done;
  } vec_t;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   done_seen = 0;
  cyc_t exp_q[$];
  vec_t tbl[$];

  // ---------------- reference model ----------------
  // Control lines each state must show, as listed in the state descriptions.
  function automatic obs_t model_out(input logic [3:0] s, input logic mr,
                                     input logic [1:0] fc);
    obs_t o;
    o = '0;
    o.st = s;
    case (s)
      4'd0:  begin o.memread = 1; o.srcb = 2'b01; o.irwrite = mr; o.pcwrite = mr; end
      4'd1:  o.srcb = 2'b11;
      4'd2:  begin o.srca = 1; o.srcb = 2'b10; end
      4'd3:  begin o.memread = 1; o.iord = 1; end
      4'd4:  begin o.memtoreg = 1; o.regwrite = 1; o.done = 1; end
      4'd5:  begin o.memwrite = 1; o.iord = 1; o.done = mr; end
      4'd6:  begin o.srca = 1; o.aluop = 2'b10; end
      4'd7:  begin o.regdst = 1; o.regwrite = 1; o.done = 1; end
      4'd8:  begin o.srca = 1; o.aluop = 2'b01; o.pcwcond = 1; o.pcsrc = 2'b01; o.done = 1; end
      4'd9:  begin o.srca = 1; o.srcb = 2'b10; end
      4'd10: begin o.regwrite = 1; o.done = 1; end
      4'd11: begin o.pcwrite = 1; o.pcsrc = 2'b10; o.done = 1; end
      4'd15: begin o.flt = 1; o.fcode = fc; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic logic [5:0] rnd_op();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expands one instruction into its cycle-by-cycle trace: fw stalled fetch
  // cycles, the completing fetch, decode, then the opcode's own path with mw
  // stalled memory cycles. Opcode is noise everywhere except DECODE/MEMADR.
  task automatic add_instr(input logic [5:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++) exp_q.push_back({1'b0, rnd_op(), 4'd0});
    exp_q.push_back({1'b1, rnd_op(), 4'd0});
    exp_q.push_back({rnd_bit(), op, 4'd1});
    case (op)
      T_RTYPE: begin
        exp_q.push_back({rnd_bit(), rnd_op(), 4'd6});
        exp_q.push_back({rnd_bit(), rnd_op(), 4'd7});
      end
      T_ADDI: begin
        exp_q.push_back({rnd_bit(), rnd_op(), 4'd9});
        exp_q.push_back({rnd_bit(), rnd_op(), 4'd10});
      end
      T_BEQ: exp_q.push_back({rnd_bit(), rnd_op(), 4'd8});
      T_J:   exp_q.push_back({rnd_bit(), rnd_op(), 4'd11});
      T_LW: begin
        exp_q.push_back({rnd_bit(), op, 4'd2});
        for (int i = 0; i < mw; i++) exp_q.push_back({1'b0, rnd_op(), 4'd3});
        exp_q.push_back({1'b1, rnd_op(), 4'd3});
        exp_q.push_back({rnd_bit(), rnd_op(), 4'd4});
      end
      default: begin
        exp_q.push_back({rnd_bit(), op, 4'd2});
        for (int i = 0; i < mw; i++) exp_q.push_back({1'b0, rnd_op(), 4'd5});
        exp_q.push_back({1'b1, rnd_op(), 4'd5});
      end
    endcase
  endtask

  // ---------------- driver + checker ----------------
  // Drives inputs just after the falling edge and checks the whole output
  // bundle 1 time unit later, well clear of the rising edge.
  task automatic step(input logic rn, input logic mr, input logic [5:0] op,
                      input logic [3:0] es, input logic [1:0] fc,
                      input string nm, output obs_t act_v);
    obs_t exp_v;
    @(negedge clk);
    rst_n = rn;
    mem_ready = mr;
    opcode = op;
    #1;
    exp_v = rn ? model_out(es, mr, fc) : '0;
    act_v = {state, fault_code, fault, instr_done, ALUOp, ALUSrcB, ALUSrcA,
             RegWrite, MemToReg, RegDst, IRWrite, MemWrite, MemRead, IorD,
             PCSrc, PCWriteCond, PCWrite};
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s cycle %0d: outputs got %h, expected %h (state got %0d, expected %0d)",
               nm, cyc, act_v, exp_v, act_v.st, exp_v.st);
    end
    if (rn && act_v.done) done_seen++;
    cyc++;
  endtask

  task automatic row(input logic mr, input logic [5:0] op, input logic [3:0] st,
                     input logic done);
    vec_t v;
    v.mr = mr; v.op = op; v.st = st; v.done = done;
    tbl.push_back(v);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    obs_t a;
    logic [5:0] legal_ops [6];
    int fw, mw;
    cyc_t c;

    legal_ops = '{T_RTYPE, T_LW, T_SW, T_ADDI, T_BEQ, T_J};

    // Reset: outputs forced to 0 while rst_n is low.
    step(1'b0, 1'b1, 6'h3f, 4'd0, 2'b00, "reset_outputs", a);
    step(1'b0, 1'b0, 6'h00, 4'd0, 2'b00, "reset_outputs", a);

    // Directed vectors: {mem_ready, opcode, expected state, expected instr_done}.
    row(1, 6'h15, 0, 0); row(1, T_RTYPE, 1, 0); row(1, 6'h23, 6, 0); row(1, 6'h2b, 7, 1);
    row(1, 6'h00, 0, 0); row(1, T_LW, 1, 0); row(1, T_LW, 2, 0);
    row(0, 6'h00, 3, 0); row(0, 6'h00, 3, 0); row(0, 6'h00, 3, 0); row(1, 6'h00, 3, 0);
    row(1, 6'h00, 4, 1);
    row(0, 6'h00, 0, 0); row(0, 6'h00, 0, 0); row(1, 6'h00, 0, 0);
    row(1, T_ADDI, 1, 0); row(0, 6'h00, 9, 0); row(0, 6'h00, 10, 1);
    row(1, 6'h00, 0, 0); row(1, T_BEQ, 1, 0); row(1, 6'h00, 8, 1);
    row(1, 6'h00, 0, 0); row(1, T_J, 1, 0); row(0, 6'h00, 11, 1);
    row(1, 6'h00, 0, 0); row(1, T_SW, 1, 0); row(1, T_SW, 2, 0); row(1, 6'h00, 5, 1);
    foreach (tbl[i]) begin
      step(1'b1, tbl[i].mr, tbl[i].op, tbl[i].st, 2'b00, "table", a);
      n_checks++;
      if (a.done !== tbl[i].done) begin
        n_fail++;
        $display("FAIL table_done row %0d: instr_done got %b, expected %b",
                 i, a.done, tbl[i].done);
      end
    end

    // Random instruction stream, with occasional stalls at the MAX_WAIT limit.
    done_seen = 0;
    for (int k = 0; k < N_RAND; k++) begin
      fw = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
      mw = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
      add_instr(legal_ops[$urandom_range(0, 5)], fw, mw);
    end
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      step(1'b1, c.mr, c.op, c.st, 2'b00, "random", a);
    end
    n_checks++;
    if (done_seen != N_RAND) begin
      n_fail++;
      $display("FAIL random_done_count: instr_done pulses got %0d, expected %0d",
               done_seen, N_RAND);
    end

    // Illegal opcode: sticky HALT with code 01 until reset.
    step(1'b1, 1'b1, 6'h00, 4'd0, 2'b00, "illegal", a);
    step(1'b1, 1'b1, 6'h3f, 4'd1, 2'b00, "illegal", a);
    for (int i = 0; i < 20; i++)
      step(1'b1, rnd_bit(), rnd_op(), 4'd15, 2'b01, "illegal_halt", a);
    step(1'b0, 1'b0, 6'h00, 4'd0, 2'b00, "illegal_reset", a);
    step(1'b1, 1'b0, 6'h00, 4'd0, 2'b00, "illegal_recover", a);

    // MEMWR timeout: 16 stalled cycles then HALT with code 10, no MemWrite.
    step(1'b1, 1'b1, 6'h00, 4'd0, 2'b00, "timeout", a);
    step(1'b1, 1'b1, T_SW, 4'd1, 2'b00, "timeout", a);
    step(1'b1, 1'b1, T_SW, 4'd2, 2'b00, "timeout", a);
    for (int i = 0; i < 16; i++)
      step(1'b1, 1'b0, rnd_op(), 4'd5, 2'b00, "timeout_wait", a);
    for (int i = 0; i < 5; i++)
      step(1'b1, rnd_bit(), rnd_op(), 4'd15, 2'b10, "timeout_halt", a);
    step(1'b0, 1'b0, 6'h00, 4'd0, 2'b00, "timeout_reset", a);

    // Same sw, but mem_ready arrives on the 16th cycle: completes normally.
    step(1'b1, 1'b1, 6'h00, 4'd0, 2'b00, "edge_wait", a);
    step(1'b1, 1'b1, T_SW, 4'd1, 2'b00, "edge_wait", a);
    step(1'b1, 1'b1, T_SW, 4'd2, 2'b00, "edge_wait", a);
    for (int i = 0; i < 15; i++)
      step(1'b1, 1'b0, rnd_op(), 4'd5, 2'b00, "edge_wait_stall", a);
    step(1'b1, 1'b1, 6'h00, 4'd5, 2'b00, "edge_wait_done", a);
    step(1'b1, 1'b0, 6'h00, 4'd0, 2'b00, "edge_wait_fetch", a);

    // Reset in the middle of a stalled lw abandons it.
    step(1'b1, 1'b1, 6'h00, 4'd0, 2'b00, "mid_reset", a);
    step(1'b1, 1'b1, T_LW, 4'd1, 2'b00, "mid_reset", a);
    step(1'b1, 1'b1, T_LW, 4'd2, 2'b00, "mid_reset", a);
    step(1'b1, 1'b0, 6'h00, 4'd3, 2'b00, "mid_reset", a);
    step(1'b0, 1'b1, 6'h00, 4'd0, 2'b00, "mid_reset_low", a);
    step(1'b1, 1'b1, 6'h00, 4'd0, 2'b00, "mid_reset_fetch", a);
    step(1'b1, 1'b1, T_J, 4'd1, 2'b00, "mid_reset_decode", a);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
